phy_rx_sync_ctrl: RTL and testbench
===================================

# phy_rx_sync_ctrl

Receive-side alignment controller for the PHY RX serial-to-parallel path. Runs on the bit clock, hunts the incoming serial stream for the comma character, locks the byte boundary, and declares the link active after a configurable run of consecutive aligned commas. Once active, it assembles bytes at the locked boundary and emits every non-comma byte as one valid pulse for the downstream demux/FIFO stage.

## Interface
Parameters:
- COMMA, 8'hBC, idle/alignment character.
- BC_COUNT, 4, consecutive aligned commas required to go active. Legal range is 1..7.

Ports:
- clk_32f  in  1  bit clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high. Dominates every other input.
- data_in  in  1  serial bit. Sampled on every clk_32f edge, MSB first.
- resync  in  1  one-cycle request that forces a return to HUNT.
- data_out  out  8  last assembled byte, registered.
- valid_out  out  1  one-cycle strobe marking data_out as a valid non-comma byte.
- active  out  1  high while in ACTIVE.
- state  out  2  debug: 0 = HUNT, 1 = ALIGN, 2 = ACTIVE.

## Operation
- Shift register `shreg[7:0]` updates every edge. Its next value is `nxt = {shreg[6:0], data_in}`. All comma and byte decisions use `nxt`, so they take effect at the same edge that samples the 8th bit.
- Bit counter `bit_cnt[2:0]`. A byte completes at an edge where `bit_cnt == 7`, and the counter then wraps to 0.

HUNT:
- Comparison is bit-by-bit at every offset.
- When `nxt == COMMA`: go to ALIGN, set `bit_cnt = 0`, set `bc_cnt = 1`.
- If BC_COUNT == 1, go directly to ACTIVE instead.

ALIGN:
- `bit_cnt` increments every edge.
- At byte completion with `nxt == COMMA`: `bc_cnt++`. When `bc_cnt` reaches BC_COUNT, go to ACTIVE.
- At byte completion with any other byte: go to HUNT and clear `bc_cnt`.
- No valid_out is produced in ALIGN.

ACTIVE:
- At every byte completion, `data_out <= nxt`.
- `valid_out <= 1` only if `nxt != COMMA`. Otherwise valid_out stays 0 and data_out still updates.
- ACTIVE persists until reset or resync. There is no automatic loss-of-sync.

resync:
- Next state is HUNT; `bc_cnt`, `bit_cnt`, `valid_out` and `active` clear.
- `shreg` keeps shifting, so a comma completing on that same edge is not detected; hunting resumes on the following edge.

Reset values:
- state = HUNT, active = 0, valid_out = 0, data_out = 8'h00.
- shreg = 0, bit_cnt = 0, bc_cnt = 0.
- Reset asserted mid-byte discards the partial byte.

## Timing
- Decision latency: the transition to ALIGN or ACTIVE, and data_out/valid_out, are registered at the edge sampling the byte's last bit. They are visible for the following clk_32f cycle.
- valid_out is high for exactly one clk_32f cycle per valid byte. Minimum spacing between strobes is 8 cycles.
- active rises at the edge completing the BC_COUNT-th comma. The first possible valid_out is 8 edges later.
- Commas detected in HUNT at a false offset (straddling two bytes) are legal hits. The next non-comma byte returns the block to HUNT, and re-hunting restarts from the current `shreg` contents on the next edge.
- Simultaneous events: reset > resync > normal transitions. If resync coincides with byte completion in ACTIVE, the byte is dropped (valid_out = 0).

## Test plan
- Reset, then stream F2, 15, BC×4, DD, 45, AA, BC, 13 MSB first.
  - No hit during F2/15.
  - ALIGN after the 1st BC; active = 1 after the 4th BC.
  - valid_out pulses with DD, 45, AA, 13; no pulse for the BC.
- False comma: in HUNT, send 5E, 00.
  - HUNT→ALIGN at bit 1 of the 00 byte.
  - Next completed byte ≠ BC, so back to HUNT; bc_cnt = 0; no valid_out.
- Broken comma run: BC, BC, BC, 55, BC×4, 77.
  - ALIGN→HUNT at the 55.
  - Re-lock on the next BC; active after the 4th BC of the second run.
  - Single valid_out with data_out = 77.
- Mid-stream events while ACTIVE:
  - Assert reset at bit 4 of a byte: all outputs 0 and state = HUNT on the next cycle; the partial byte produces no valid_out.
  - Assert resync on a byte-completion edge: no valid_out, active = 0.
- BC_COUNT = 1: a single BC gives active = 1 at that edge; a following A5 yields valid_out with data_out = A5, 8 cycles later.

Source files
------------

// File: rtl/phy_rx_sync_ctrl.sv
// Receive-side comma alignment controller: hunts for COMMA, locks the byte
// boundary after BC_COUNT aligned commas, then strobes out non-comma bytes.
module phy_rx_sync_ctrl #(
    parameter logic [7:0] COMMA    = 8'hBC,
    parameter int         BC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       resync,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [2:0] BC_TARGET = 3'(BC_COUNT);

    state_t     r_state;
    logic [7:0] r_shreg;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_bc_cnt;
    logic [7:0] r_data_out;
    logic       r_valid;

    state_t     w_state_nxt;
    logic [7:0] w_nxt;
    logic       w_is_comma;
    logic       w_byte_done;
    logic [2:0] w_bit_cnt_nxt;
    logic [2:0] w_bc_cnt_nxt;
    logic [2:0] w_bc_inc;
    logic       w_load;
    logic       w_valid_nxt;

    // Decisions look at the byte including the bit being sampled this edge.
    assign w_nxt       = {r_shreg[6:0], data_in};
    assign w_is_comma  = (w_nxt == COMMA);
    assign w_byte_done = (r_bit_cnt == 3'd7);
    assign w_bc_inc    = r_bc_cnt + 3'd1;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state    <= HUNT;
            r_shreg    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_bc_cnt   <= 3'd0;
            r_data_out <= 8'h00;
            r_valid    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bc_cnt  <= w_bc_cnt_nxt;
            r_valid   <= w_valid_nxt;
            if (w_load) begin
                r_data_out <= w_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        w_bc_cnt_nxt  = r_bc_cnt;
        w_load        = 1'b0;
        w_valid_nxt   = 1'b0;
        if (resync) begin
            // Shift register keeps running; a comma completing here is ignored.
            w_state_nxt   = HUNT;
            w_bit_cnt_nxt = 3'd0;
            w_bc_cnt_nxt  = 3'd0;
        end else begin
            case (r_state)
                HUNT: begin
                    w_bit_cnt_nxt = 3'd0;
                    if (w_is_comma) begin
                        w_bc_cnt_nxt = 3'd1;
                        w_state_nxt  = (BC_TARGET == 3'd1) ? ACTIVE : ALIGN;
                    end
                end
                ALIGN: begin
                    if (w_byte_done) begin
                        if (w_is_comma) begin
                            w_bc_cnt_nxt = w_bc_inc;
                            if (w_bc_inc == BC_TARGET) begin
                                w_state_nxt = ACTIVE;
                            end
                        end else begin
                            w_state_nxt   = HUNT;
                            w_bc_cnt_nxt  = 3'd0;
                            w_bit_cnt_nxt = 3'd0;
                        end
                    end
                end
                ACTIVE: begin
                    if (w_byte_done) begin
                        w_load      = 1'b1;
                        w_valid_nxt = !w_is_comma;
                    end
                end
                default: begin
                    w_state_nxt   = HUNT;
                    w_bit_cnt_nxt = 3'd0;
                    w_bc_cnt_nxt  = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        state     = r_state;
        active    = (r_state == ACTIVE);
        data_out  = r_data_out;
        valid_out = r_valid;
    end

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed bench for phy_rx_sync_ctrl: comma hunt, lock, data strobes,
// false commas, broken runs, reset/resync while active, and BC_COUNT = 1.
module tb_phy_rx_sync_ctrl;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic       resync  = 1'b0;

    logic [7:0] data_out,  data_out1;
    logic       valid_out, valid_out1;
    logic       active,    active1;
    logic [1:0] state,     state1;

    int n_chk  = 0;
    int n_fail = 0;
    int vcnt   = 0;
    int vcnt1  = 0;

    always #5 clk_32f = ~clk_32f;

    phy_rx_sync_ctrl #(.COMMA(8'hBC), .BC_COUNT(4)) dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .resync   (resync),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active),
        .state    (state)
    );

    phy_rx_sync_ctrl #(.COMMA(8'hBC), .BC_COUNT(1)) dut1 (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .resync   (resync),
        .data_out (data_out1),
        .valid_out(valid_out1),
        .active   (active1),
        .state    (state1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bit per clock; inputs change 1 time unit after the rising edge.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        if (valid_out === 1'b1) vcnt++;
        if (valid_out1 === 1'b1) vcnt1++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        data_in = 1'b0;
        @(posedge clk_32f);
        #1;
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        vcnt  = 0;
        vcnt1 = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'h00);

        // Basic lock and data stream
        send_byte(8'hF2);
        chk("f2_hunt", 32'(state), 32'd0);
        send_byte(8'h15);
        chk("15_hunt", 32'(state), 32'd0);
        send_byte(8'hBC);
        chk("bc1_align", 32'(state), 32'd1);
        chk("bc1_inactive", 32'(active), 32'd0);
        send_byte(8'hBC);
        chk("bc2_align", 32'(state), 32'd1);
        send_byte(8'hBC);
        chk("bc3_align", 32'(state), 32'd1);
        send_byte(8'hBC);
        chk("bc4_state", 32'(state), 32'd2);
        chk("bc4_active", 32'(active), 32'd1);
        chk("bc4_novalid", 32'(valid_out), 32'd0);
        chk("lock_pulses", 32'(vcnt), 32'd0);
        send_byte(8'hDD);
        chk("dd_valid", 32'(valid_out), 32'd1);
        chk("dd_data", 32'(data_out), 32'hDD);
        send_bit(1'b0);
        chk("dd_onecycle", 32'(valid_out), 32'd0);
        for (int i = 6; i >= 0; i--) send_bit(1'(8'h45 >> i));
        chk("45_valid", 32'(valid_out), 32'd1);
        chk("45_data", 32'(data_out), 32'h45);
        send_byte(8'hAA);
        chk("aa_valid", 32'(valid_out), 32'd1);
        chk("aa_data", 32'(data_out), 32'hAA);
        send_byte(8'hBC);
        chk("bc_novalid", 32'(valid_out), 32'd0);
        chk("bc_data", 32'(data_out), 32'hBC);
        send_byte(8'h13);
        chk("13_valid", 32'(valid_out), 32'd1);
        chk("13_data", 32'(data_out), 32'h13);
        chk("stream_pulses", 32'(vcnt), 32'd4);

        // False comma straddling 5E/00
        do_reset();
        send_byte(8'h5E);
        chk("5e_hunt", 32'(state), 32'd0);
        send_bit(1'b0);
        chk("false_hit_align", 32'(state), 32'd1);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        chk("false_still_align", 32'(state), 32'd1);
        send_bit(1'b0);
        chk("false_back_hunt", 32'(state), 32'd0);
        chk("false_bc_clear", 32'(dut.r_bc_cnt), 32'd0);
        chk("false_pulses", 32'(vcnt), 32'd0);

        // Broken comma run then relock
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("run1_align", 32'(state), 32'd1);
        send_byte(8'h55);
        chk("55_hunt", 32'(state), 32'd0);
        send_byte(8'hBC);
        chk("relock_align", 32'(state), 32'd1);
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("run2_bc3_inactive", 32'(active), 32'd0);
        send_byte(8'hBC);
        chk("run2_active", 32'(active), 32'd1);
        send_byte(8'h77);
        chk("77_valid", 32'(valid_out), 32'd1);
        chk("77_data", 32'(data_out), 32'h77);
        chk("run_pulses", 32'(vcnt), 32'd1);

        // Reset at bit 4 of a byte while active
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        chk("pre_rst_active", 32'(active), 32'd1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        send_bit(1'b1);
        reset = 1'b0;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_active", 32'(active), 32'd0);
        chk("midrst_valid", 32'(valid_out), 32'd0);
        chk("midrst_data", 32'(data_out), 32'h00);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("midrst_after_state", 32'(state), 32'd0);
        chk("midrst_pulses", 32'(vcnt), 32'd0);

        // Resync on a byte-completion edge while active
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        send_byte(8'hDD);
        chk("pre_resync_valid", 32'(valid_out), 32'd1);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h45 >> i));
        resync = 1'b1;
        send_bit(1'b1);
        resync = 1'b0;
        chk("resync_valid", 32'(valid_out), 32'd0);
        chk("resync_active", 32'(active), 32'd0);
        chk("resync_state", 32'(state), 32'd0);
        chk("resync_data_kept", 32'(data_out), 32'hDD);
        chk("resync_pulses", 32'(vcnt), 32'd1);

        // BC_COUNT = 1 instance
        do_reset();
        send_byte(8'hBC);
        chk("bc1cfg_active", 32'(active1), 32'd1);
        chk("bc1cfg_state", 32'(state1), 32'd2);
        chk("bc1cfg_novalid", 32'(valid_out1), 32'd0);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hA5 >> i));
        chk("bc1cfg_early", 32'(valid_out1), 32'd0);
        send_bit(1'b1);
        chk("bc1cfg_valid", 32'(valid_out1), 32'd1);
        chk("bc1cfg_data", 32'(data_out1), 32'hA5);
        chk("bc1cfg_pulses", 32'(vcnt1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
